mdu_iterative: RTL

- Iterative RV64M multiply/divide unit.
- Produces the M-extension result that feeds the writeback result mux.
- Accepts the two register operands and funct3 from decode, iterates one bit per clock, and returns a single 64-bit result with a one-cycle done pulse.
- The core stalls PC update and register write while o_busy is high.

---
 rtl/mdu_pkg.sv | 43 ++++
 rtl/mdu_div_step.sv | 23 ++
 rtl/mdu_iterative.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared types and decode helpers for the iterative RV64M multiply/divide unit.
package mdu_pkg;

    localparam int unsigned XLEN = 64;

    // funct3 encodings of the M extension
    typedef enum logic [2:0] {
        MUL    = 3'b000,
        MULH   = 3'b001,
        MULHSU = 3'b010,
        MULHU  = 3'b011,
        DIV    = 3'b100,
        DIVU   = 3'b101,
        REM    = 3'b110,
        REMU   = 3'b111
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } mdu_state_e;

    function automatic logic is_div(mdu_op_e op);
        return (op == DIV) || (op == DIVU) || (op == REM) || (op == REMU);
    endfunction

    function automatic logic is_rem(mdu_op_e op);
        return (op == REM) || (op == REMU);
    endfunction

    // rs1 is treated as signed
    function automatic logic is_signed_a(mdu_op_e op);
        return (op == MULH) || (op == MULHSU) || (op == DIV) || (op == REM);
    endfunction

    // rs2 is treated as signed
    function automatic logic is_signed_b(mdu_op_e op);
        return (op == MULH) || (op == DIV) || (op == REM);
    endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One combinational restoring-divide iteration on a {remainder, quotient} pair.
module mdu_div_step #(
    parameter int unsigned W = 64
) (
    input  logic [2*W-1:0] rq_i,
    input  logic [W-1:0]   divisor_i,
    output logic [2*W-1:0] rq_o
);

    logic [W:0]   partial;
    logic [W-1:0] diff;
    logic         ge;

    // Shift left by one, compare against the divisor, subtract when it fits.
    // The partial remainder needs W+1 bits: the bit shifted out of the top is kept.
    always_comb begin
        partial = rq_i[2*W-1:W-1];
        ge      = (partial >= {1'b0, divisor_i});
        diff    = partial[W-1:0] - divisor_i;
        rq_o    = {(ge ? diff : partial[W-1:0]), rq_i[W-2:0], ge};
    end

endmodule

// File: rtl/mdu_iterative.sv
// Iterative RV64M multiply/divide unit: one bit per clock, fixed latency.
module mdu_iterative #(
    parameter int unsigned XLEN = 64
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_start,
    input  logic            i_kill,
    input  logic [2:0]      i_op,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    output logic            o_busy,
    output logic            o_done,
    output logic [XLEN-1:0] o_result
);
    import mdu_pkg::*;

    localparam int unsigned     CW   = $clog2(XLEN);
    localparam logic [CW-1:0]   LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    mdu_state_e        state_q;
    logic [CW-1:0]     cnt_q;
    mdu_op_e           op_q;
    logic              sign_a_q;
    logic              sign_b_q;
    logic [XLEN-1:0]   mcand_q;     // multiplicand or divisor magnitude
    logic [2*XLEN-1:0] acc_q;       // product register or {rem, quot}
    logic [2*XLEN-1:0] acc_d;
    logic [XLEN-1:0]   result_q;
    logic [XLEN-1:0]   result_d;
    logic              done_q;
    logic              busy_q;

    mdu_op_e           op_in;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic              special;
    logic [XLEN-1:0]   special_res;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [2*XLEN-1:0] div_next;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot;
    logic [XLEN-1:0]   rem;

    assign op_in = mdu_op_e'(i_op);

    // Launch decode: operand magnitudes and divide special cases.
    always_comb begin
        mag_a       = (is_signed_a(op_in) && i_rs1[XLEN-1]) ? -i_rs1 : i_rs1;
        mag_b       = (is_signed_b(op_in) && i_rs2[XLEN-1]) ? -i_rs2 : i_rs2;
        special     = 1'b0;
        special_res = '0;
        if (is_div(op_in) && (i_rs2 == '0)) begin
            special     = 1'b1;
            special_res = is_rem(op_in) ? i_rs1 : '1;
        end else if (((op_in == DIV) || (op_in == REM)) && (i_rs1 == SMIN) && (i_rs2 == '1)) begin
            special     = 1'b1;
            special_res = (op_in == DIV) ? SMIN : '0;
        end
    end

    mdu_div_step #(
        .W(XLEN)
    ) u_div_step (
        .rq_i      (acc_q),
        .divisor_i (mcand_q),
        .rq_o      (div_next)
    );

    // Shift-add multiply step; the carry out of the upper-half add is shifted in.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, mcand_q};
        mul_next = acc_q[0] ? {mul_sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};
        acc_d    = is_div(op_q) ? div_next : mul_next;
    end

    // Sign correction and result selection for the FIX cycle.
    always_comb begin
        prod_fix = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
        quot     = acc_q[XLEN-1:0];
        rem      = acc_q[2*XLEN-1:XLEN];
        case (op_q)
            MUL:                 result_d = prod_fix[XLEN-1:0];
            MULH, MULHSU, MULHU: result_d = prod_fix[2*XLEN-1:XLEN];
            DIV:                 result_d = (sign_a_q ^ sign_b_q) ? -quot : quot;
            REM:                 result_d = sign_a_q ? -rem : rem;
            DIVU:                result_d = quot;
            default:             result_d = rem;
        endcase
    end

    // Control FSM and datapath registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= MUL;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            mcand_q  <= '0;
            acc_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else if (i_kill && (state_q != IDLE)) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (i_start && !i_kill) begin
                        op_q     <= op_in;
                        sign_a_q <= is_signed_a(op_in) & i_rs1[XLEN-1];
                        sign_b_q <= is_signed_b(op_in) & i_rs2[XLEN-1];
                        mcand_q  <= is_div(op_in) ? mag_b : mag_a;
                        acc_q    <= {{XLEN{1'b0}}, (is_div(op_in) ? mag_a : mag_b)};
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        if (special) begin
                            result_q <= special_res;
                            done_q   <= 1'b1;
                            state_q  <= DONE;
                        end else begin
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    result_q <= result_d;
                    done_q   <= 1'b1;
                    state_q  <= DONE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign o_busy   = busy_q;
    assign o_done   = done_q;
    assign o_result = result_q;

endmodule
